// File: rtl/hex_digits_pio_blink.sv
// Avalon-MM output PIO for the HEX-digit displays: data register with atomic
// set/clear, per-bit blink mask and a programmable blink prescaler.
module hex_digits_pio_blink #(
  parameter int unsigned                 DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0]       RESET_VALUE = '0,
  parameter int unsigned                 DIV_WIDTH   = 24,
  parameter logic [DIV_WIDTH-1:0]        DIV_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  // Bus handshake: a write is accepted on every rising edge where
  // chipselect=1 and write_n=0 (zero wait states, no backpressure); reads are
  // combinational from address with no chipselect qualification.
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DIV_WIDTH-1:0]  r_presc;
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic                  r_phase;

  logic                  w_write;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DIV_WIDTH-1:0]  w_wpresc;
  logic                  w_unused_wdata;

  assign w_write        = chipselect & ~write_n;
  assign w_wdata        = writedata[DATA_WIDTH-1:0];
  assign w_wpresc       = writedata[DIV_WIDTH-1:0];
  assign w_unused_wdata = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= RESET_VALUE;
      r_mask  <= '0;
      r_presc <= DIV_RESET;
      r_cnt   <= DIV_RESET;
      r_phase <= 1'b0;
    end else begin
      if (w_write) begin
        case (address)
          ADDR_DATA:     r_data <= w_wdata;
          ADDR_MASK:     r_mask <= w_wdata;
          ADDR_OUTSET:   r_data <= r_data | w_wdata;
          ADDR_OUTCLEAR: r_data <= r_data & ~w_wdata;
          default:       ;
        endcase
      end

      // Divider reloads on a PRESCALE write so the new period starts cleanly.
      if (w_write && address == ADDR_PRESCALE) begin
        r_presc <= w_wpresc;
        r_cnt   <= w_wpresc;
        r_phase <= 1'b0;
      end else if (r_presc == '0) begin
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else if (r_cnt == '0) begin
        r_cnt   <= r_presc;
        r_phase <= ~r_phase;
      end else begin
        r_cnt   <= r_cnt - DIV_WIDTH'(1);
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[DATA_WIDTH-1:0] = r_data;
      ADDR_MASK:     readdata[DATA_WIDTH-1:0] = r_mask;
      ADDR_PRESCALE: readdata[DIV_WIDTH-1:0]  = r_presc;
      ADDR_STATUS:   readdata[0]              = r_phase;
      default:       readdata = '0;
    endcase
  end

  assign out_port = r_data & ~(r_mask & {DATA_WIDTH{r_phase}});

endmodule

// File: tb/tb_hex_digits_pio_blink.sv
// Self-checking bench for hex_digits_pio_blink with a cycle-count based
// reference model of the register file and blink phase.
module tb_hex_digits_pio_blink;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] out_port;

  int n_cmp = 0;
  int n_err = 0;

  hex_digits_pio_blink dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: phase derived from edges elapsed since the last PRESCALE write
  logic [15:0] m_data;
  logic [15:0] m_mask;
  logic [23:0] m_presc;
  int          m_since;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data  = 16'h0000;
      m_mask  = 16'h0000;
      m_presc = 24'h0;
      m_since = 0;
    end else begin
      m_since = m_since + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata[15:0];
          3'd1: m_mask = writedata[15:0];
          3'd2: begin m_presc = writedata[23:0]; m_since = 0; end
          3'd4: m_data = m_data | writedata[15:0];
          3'd5: m_data = m_data & ~writedata[15:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic exp_phase();
    if (m_presc == 0) return 1'b0;
    return ((m_since / (int'(m_presc) + 1)) % 2) == 1;
  endfunction

  function automatic logic [15:0] exp_out();
    return exp_phase() ? (m_data & ~m_mask) : m_data;
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    case (a)
      3'd0: return {16'h0, m_data};
      3'd1: return {16'h0, m_mask};
      3'd2: return {8'h0, m_presc};
      3'd3: return {31'h0, exp_phase()};
      default: return 32'h0;
    endcase
  endfunction

  // driver tasks
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_model_phase(input logic ph, input string name);
    int k;
    for (k = 0; k < 40 && exp_phase() != ph; k++) idle_cycle();
    if (exp_phase() != ph) begin
      n_cmp++; n_err++;
      $display("FAIL %s: phase wait timed out", name);
    end
  endtask

  // tests
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_port !== 16'h0000) begin
      n_err++; $display("FAIL reset_out: got %h exp 0000", out_port);
    end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); #1;
      n_cmp++;
      if (readdata !== 32'h0) begin
        n_err++; $display("FAIL reset_read@%0d: got %h exp 0", a, readdata);
      end
    end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_data_write();
    bus_write(3'd0, 32'hFFFF1234);
    address = 3'd0; #1;
    n_cmp++;
    if (out_port !== 16'h1234) begin
      n_err++; $display("FAIL data_out: got %h exp 1234", out_port);
    end
    n_cmp++;
    if (readdata !== 32'h00001234) begin
      n_err++; $display("FAIL data_read: got %h exp 00001234", readdata);
    end
  endtask

  task automatic test_set_clear();
    bus_write(3'd4, 32'h0000000F);
    n_cmp++;
    if (out_port !== 16'h123F) begin
      n_err++; $display("FAIL outset: got %h exp 123f", out_port);
    end
    bus_write(3'd5, 32'h00001200);
    n_cmp++;
    if (out_port !== 16'h003F) begin
      n_err++; $display("FAIL outclear: got %h exp 003f", out_port);
    end
    for (int a = 4; a < 8; a++) begin
      address = 3'(a); #1;
      n_cmp++;
      if (readdata !== 32'h0) begin
        n_err++; $display("FAIL wo_read@%0d: got %h exp 0", a, readdata);
      end
    end
  endtask

  task automatic test_blink();
    logic [15:0] e;
    bus_write(3'd1, 32'h000000F0);
    bus_write(3'd2, 32'h00000003);
    address = 3'd3;
    for (int k = 0; k < 16; k++) begin
      // phase flips every 4 edges after the PRESCALE write edge
      e = (((k / 4) % 2) == 1) ? 16'h000F : 16'h003F;
      #1;
      n_cmp++;
      if (out_port !== e) begin
        n_err++; $display("FAIL blink_out k=%0d: got %h exp %h", k, out_port, e);
      end
      n_cmp++;
      if (readdata[0] !== (e == 16'h000F)) begin
        n_err++; $display("FAIL blink_status k=%0d: got %b exp %b", k, readdata[0], e == 16'h000F);
      end
      idle_cycle();
    end
  endtask

  task automatic test_presc_off();
    wait_model_phase(1'b1, "presc_off_wait");
    bus_write(3'd2, 32'h0);
    address = 3'd3;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++;
      if (out_port !== 16'h003F || readdata !== 32'h0) begin
        n_err++;
        $display("FAIL presc_off k=%0d: got out=%h st=%h exp out=003f st=0", k, out_port, readdata);
      end
      idle_cycle();
    end
  endtask

  task automatic test_data_during_blink();
    int n;
    bus_write(3'd2, 32'h3);
    wait_model_phase(1'b1, "dblink_wait");
    bus_write(3'd0, 32'h000000FF);
    n_cmp++;
    if (out_port !== 16'h000F) begin
      n_err++; $display("FAIL dblink_out: got %h exp 000f", out_port);
    end
    // write lands on edge 5 after the PRESCALE write; phase drops at edge 8
    address = 3'd3;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      idle_cycle();
      n++;
      if (readdata[0] == 1'b0) break;
    end
    n_cmp++;
    if (n !== 3) begin
      n_err++; $display("FAIL dblink_timing: got %0d cycles exp 3", n);
    end
    n_cmp++;
    if (out_port !== 16'h00FF) begin
      n_err++; $display("FAIL dblink_phase0: got %h exp 00ff", out_port);
    end
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] r;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 3'($urandom_range(0, 7));
        d = $urandom;
        if (a == 3'd2) begin
          r = $urandom;
          d = (r & 32'hFF00_0000) | 32'($urandom_range(0, 6));
        end
        bus_write(a, d);
      end else begin
        idle_cycle();
      end
      address = 3'($urandom_range(0, 7));
      #1;
      n_cmp++;
      if (out_port !== exp_out()) begin
        n_err++; $display("FAIL rand_out k=%0d: got %h exp %h", k, out_port, exp_out());
      end
      n_cmp++;
      if (readdata !== exp_read(address)) begin
        n_err++;
        $display("FAIL rand_read k=%0d a=%0d: got %h exp %h", k, address, readdata, exp_read(address));
      end
    end
  endtask

  task automatic test_async_reset();
    bus_write(3'd0, 32'h003F);
    bus_write(3'd1, 32'h00F0);
    bus_write(3'd2, 32'h2);
    wait_model_phase(1'b1, "areset_wait");
    n_cmp++;
    if (out_port !== 16'h000F) begin
      n_err++; $display("FAIL areset_pre: got %h exp 000f", out_port);
    end
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_port !== 16'h0000) begin
      n_err++; $display("FAIL areset_out: got %h exp 0000", out_port);
    end
    @(negedge clk) reset_n = 1'b1;
    address = 3'd1; #1;
    n_cmp++;
    if (readdata !== 32'h0) begin
      n_err++; $display("FAIL areset_mask: got %h exp 0", readdata);
    end
    address = 3'd2; #1;
    n_cmp++;
    if (readdata !== 32'h0) begin
      n_err++; $display("FAIL areset_presc: got %h exp 0", readdata);
    end
    for (int k = 0; k < 6; k++) begin
      idle_cycle();
      address = 3'd3; #1;
      n_cmp++;
      if (out_port !== 16'h0000 || readdata !== 32'h0) begin
        n_err++;
        $display("FAIL areset_after k=%0d: got out=%h st=%h exp 0/0", k, out_port, readdata);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    test_reset();
    test_data_write();
    test_set_clear();
    test_blink();
    test_presc_off();
    test_data_during_blink();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
